uart_rx_ble: RTL and testbench
==============================

// Module: uart_rx_ble
// PURPOSE
//   Serial receiver for the BLE command link: 8N1 UART frames in on RX, parallel byte out.
//   - Direct consumer of the host-side UART_tx stream; feeds cmd bytes ('g' go, 's' stop)
//     to the Segway authorization logic.
//   - Samples each bit at mid-period, rejects glitch starts, holds the byte with a rdy flag
//     until the consumer clears it.
// PARAMETERS
//   BAUD_DIV   2604   clk cycles per bit (50 MHz / 19200 baud); must be >= 4
// PORTS
//   clk       in   1   system clock, rising edge
//   rst_n     in   1   reset, asynchronous, active-low
//   RX        in   1   serial input, idle high; asynchronous to clk
//   clr_rdy   in   1   consumer acknowledge; clears rdy
//   rx_data   out  8   last received byte, LSB received first
//   rdy       out  1   byte valid; held until cleared
//   frm_err   out  1   stop-bit framing error flag (see CONFIGURATION)
// BEHAVIOUR
//   Clocking/reset
//   - Single clock domain: clk.
//   - Reset rst_n is asynchronous, active-low.
//   - Reset values: rx_data=8'h00, rdy=0, frm_err=0, state=IDLE.
//   - Both RX synchronizer flops reset to 1 (preset), so no false start edge out of reset.
//   Input sync
//   - RX passes through a 2-flop synchronizer (rx_s).
//   - Start detection uses rx_s and its 1-cycle delayed copy.
//   State machine: IDLE, RECEIVE
//   - IDLE -> RECEIVE on a falling edge of rx_s. On entry:
//     - baud_cnt loads BAUD_DIV/2 (integer divide);
//     - bit_cnt loads 0;
//     - rdy clears (a new frame overrides an unacknowledged byte).
//   - In RECEIVE, baud_cnt decrements every clk. At baud_cnt==0 it samples rx_s and
//     reloads BAUD_DIV-1, so samples fall BAUD_DIV cycles apart, at bit centres.
//   - Sample 0 (start bit): if rx_s==1, this is a false start -> IDLE. No rdy, no data change.
//   - Samples 1..9 shift right into a 9-bit shift register shft[8:0], new bit entering at shft[8].
//     - After sample 9: shft[7:0] = data byte, shft[8] = stop bit.
//     - Then go to IDLE, load rx_data <= shft[7:0] and set rdy in the same cycle.
//   - Latency: rdy rises BAUD_DIV/2 + 9*BAUD_DIV + 3 cycles after the RX falling edge
//     (+2 synchronizer, +1 register).
//   - Back-to-back frames: the stop sample sits mid-stop-bit, so the next start edge is detectable.
//     A start edge present on the same cycle as the return to IDLE is caught on the next cycle.
//   Handshake
//   - rdy stays high until clr_rdy=1 or the next start edge.
//   - If clr_rdy and the end-of-frame rdy set happen in the same cycle, set wins: rdy=1.
//   - rx_data changes only when rdy is set; it is stable while rdy=1.
//   Boundaries
//   - RX stuck low (break): one frame completes per the stop-bit rule, then the FSM waits in
//     IDLE for a new falling edge.
//   - clr_rdy with rdy=0: no effect.
//   - rst_n asserted mid-frame: immediate abort to reset values; partial byte discarded.
//   Counter widths: baud_cnt = $clog2(BAUD_DIV) bits; bit_cnt = 4 bits.
// CONFIGURATION
//   UART_RX_FRAME_CHECK_EN
//   - Defined: after sample 9, if shft[8]==0:
//     - frm_err=1 for that frame and rdy is NOT set;
//     - rx_data is NOT updated.
//     A valid frame (stop=1) clears frm_err, as does a clr_rdy pulse.
//   - Undefined: stop bit is ignored, every completed frame sets rdy, and frm_err is tied 0.
// TESTING
//   - Reset, RX=1, 20000 clks -> rdy=0, rx_data=00, frm_err=0.
//   - UART_tx sends 8'h67 ('g') -> rdy rises within +/-2 clks of 24742 clks after the start edge;
//     rx_data=67. Pulse clr_rdy -> rdy=0 next clk.
//   - Back-to-back 8'h67 then 8'h73 ('s') without clr_rdy:
//     - rdy drops at the second start edge;
//     - then rdy=1 with rx_data=73.
//   - RX low for 1000 clks, then high -> no rdy for 30000 clks; rx_data unchanged.
//   - Frame 8'hA5 with stop bit forced 0:
//     - with UART_RX_FRAME_CHECK_EN: frm_err=1, rdy=0, rx_data unchanged;
//     - without it: rdy=1, rx_data=A5.
//   - rst_n pulsed low mid-data (after bit 4) -> outputs at reset values. A following clean
//     8'h3C frame -> rdy=1, rx_data=3C.

Source files
------------

// File: rtl/uart_rx_ble.sv
// uart_rx_ble: 8N1 UART receiver for the BLE command link, sampling each bit at its centre.
// Define UART_RX_FRAME_CHECK_EN to reject frames whose stop bit is 0 and flag them on frm_err.
module uart_rx_ble #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [0:0] IDLE = 1'b0, RECEIVE = 1'b1;
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2), FULL = CW'(BAUD_DIV - 1);
  logic          r_rx_meta, r_rx_s, r_rx_d, r_pend;
  logic [0:0]    r_state;
  logic [CW-1:0] r_baud_cnt;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shft;
  logic          w_edge, w_start, w_tick, w_done, w_ok;
  assign w_edge  = r_rx_d & ~r_rx_s;
  assign w_start = (r_state == IDLE) & (w_edge | r_pend);
  assign w_tick  = (r_state == RECEIVE) & (r_baud_cnt == '0);
  assign w_done  = w_tick & (r_bit_cnt == 4'd9);
`ifdef UART_RX_FRAME_CHECK_EN
  logic r_frm_err;
  assign w_ok    = w_done & r_rx_s;
  assign frm_err = r_frm_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_frm_err <= 1'b0;
    else if (w_done) r_frm_err <= ~r_rx_s;
    else if (clr_rdy) r_frm_err <= 1'b0;
`else
  assign w_ok    = w_done;
  assign frm_err = 1'b0;
`endif
  // Synchronizer flops preset high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  // An edge arriving on the stop-sample cycle is remembered and started one cycle later.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= 4'd0;
      r_shft     <= 8'h00;
      r_pend     <= 1'b0;
    end else begin
      r_pend <= w_done & w_edge;
      if (r_state == IDLE) begin
        if (w_start) begin
          r_state    <= RECEIVE;
          r_baud_cnt <= HALF;
          r_bit_cnt  <= 4'd0;
        end
      end else if (w_tick) begin
        r_baud_cnt <= FULL;
        r_bit_cnt  <= r_bit_cnt + 4'd1;
        if (r_bit_cnt != 4'd0) r_shft <= {r_rx_s, r_shft[7:1]};
        if (((r_bit_cnt == 4'd0) & r_rx_s) | w_done) r_state <= IDLE;
      end else begin
        r_baud_cnt <= r_baud_cnt - CW'(1);
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_data <= 8'h00;
      rdy     <= 1'b0;
    end else if (w_start) begin
      rdy <= 1'b0;
    end else if (w_ok) begin
      rdy     <= 1'b1;
      rx_data <= r_shft;
    end else if (clr_rdy) begin
      rdy <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_ble.sv
// tb_uart_rx_ble: directed scoreboard bench for uart_rx_ble with a short bit period.
module tb_uart_rx_ble;
  localparam int B = 16;
  localparam int L = B / 2 + 9 * B + 3;
  logic       clk = 1'b0, rst_n = 1'b0, RX = 1'b1, clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy, frm_err;
  int         vectors = 0, errs = 0, cyc = 0, t0 = 0, nrise = 0;
  logic       prev_rdy = 1'b0;
  logic [7:0] sb[$];

  uart_rx_ble #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .clr_rdy(clr_rdy),
    .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rdy && !prev_rdy) begin
      nrise++;
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) chk("rx_data", rx_data, sb.pop_front());
      vectors++;
      assert ((cyc - t0 >= L - 2) && (cyc - t0 <= L + 2)) else begin
        errs++;
        $error("FAIL latency: observed %0d expected %0d +/-2", cyc - t0, L);
      end
    end
    prev_rdy = rdy;
  end

  task automatic drive(input logic [7:0] b, input logic stop, input int from, input int to);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = from; i < to; i++) begin
      @(negedge clk);
      RX = f[i];
      if (i == 0) t0 = cyc;
      repeat (B - 1) @(negedge clk);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20 * B) @(negedge clk);
    chk("reset_rdy", rdy, 0);
    chk("reset_data", rx_data, 8'h00);
    chk("reset_frm", frm_err, 0);
    sb.push_back(8'h67);
    drive(8'h67, 1'b1, 0, 10);
    repeat (4) @(negedge clk);
    chk("g_rdy", rdy, 1);
    chk("g_data", rx_data, 8'h67);
    pulse_clr();
    chk("clr_rdy", rdy, 0);
    sb.push_back(8'h67);
    drive(8'h67, 1'b1, 0, 10);
    chk("b2b_first_rdy", rdy, 1);
    drive(8'h73, 1'b1, 0, 1);
    chk("b2b_drop", rdy, 0);
    sb.push_back(8'h73);
    drive(8'h73, 1'b1, 1, 10);
    repeat (4) @(negedge clk);
    chk("s_rdy", rdy, 1);
    chk("s_data", rx_data, 8'h73);
    pulse_clr();
    n = nrise;
    @(negedge clk);
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    repeat (30 * B) @(negedge clk);
    chk("glitch_no_rdy", nrise - n, 0);
    chk("glitch_data", rx_data, 8'h73);
`ifdef UART_RX_FRAME_CHECK_EN
    drive(8'hA5, 1'b0, 0, 10);
    RX = 1'b1;
    repeat (4) @(negedge clk);
    chk("bad_stop_frm", frm_err, 1);
    chk("bad_stop_rdy", rdy, 0);
    chk("bad_stop_data", rx_data, 8'h73);
`else
    sb.push_back(8'hA5);
    drive(8'hA5, 1'b0, 0, 10);
    RX = 1'b1;
    repeat (4) @(negedge clk);
    chk("bad_stop_rdy", rdy, 1);
    chk("bad_stop_data", rx_data, 8'hA5);
`endif
    pulse_clr();
    chk("clr_frm", frm_err, 0);
    chk("clr_rdy2", rdy, 0);
    pulse_clr();
    chk("clr_idle_rdy", rdy, 0);
    n = nrise;
`ifndef UART_RX_FRAME_CHECK_EN
    sb.push_back(8'h00);
`endif
    drive(8'h00, 1'b0, 0, 10);
    repeat (3 * B) @(negedge clk);
`ifdef UART_RX_FRAME_CHECK_EN
    chk("break_rises", nrise - n, 0);
    chk("break_frm", frm_err, 1);
`else
    chk("break_rises", nrise - n, 1);
    chk("break_data", rx_data, 8'h00);
`endif
    RX = 1'b1;
    repeat (2 * B) @(negedge clk);
    pulse_clr();
    sb.push_back(8'h5A);
    drive(8'h5A, 1'b1, 0, 10);
    repeat (4) @(negedge clk);
    chk("pre_rst_data", rx_data, 8'h5A);
    drive(8'hFF, 1'b1, 0, 6);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy", rdy, 0);
    chk("midrst_data", rx_data, 8'h00);
    chk("midrst_frm", frm_err, 0);
    RX = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * B) @(negedge clk);
    sb.push_back(8'h3C);
    drive(8'h3C, 1'b1, 0, 10);
    repeat (4) @(negedge clk);
    chk("post_rst_rdy", rdy, 1);
    chk("post_rst_data", rx_data, 8'h3C);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
